// File: rtl/booth_mac_ctrl.sv
// Operand FIFO and sequencer around a sequential Booth multiplier; accumulates products into a dot-product sum.
// A pair issues 2 cycles after it is pushed into an idle, empty FIFO; in_ready = !full; out_valid holds until out_ready.
module booth_mac_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int ACC_WIDTH      = 24,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_m,
  input  logic [DATA_WIDTH-1:0]   in_q,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_WIDTH-1:0]    out_sum,
  output logic [7:0]              out_count,
  output logic                    out_ovf,
  output logic                    mul_start,
  output logic [DATA_WIDTH-1:0]   mul_m,
  output logic [DATA_WIDTH-1:0]   mul_q,
  input  logic [2*DATA_WIDTH-1:0] mul_p,
  input  logic                    mul_done,
  input  logic                    mul_busy,
  output logic                    err_timeout
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] q;
    logic [DATA_WIDTH-1:0] m;
  } pair_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_t;

  state_t                state_q, state_d;
  pair_t                 mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         fcnt_q, fcnt_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  ovf_q, ovf_d, last_q, last_d, start_q, start_d, err_q, err_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [DATA_WIDTH-1:0] m_q, m_d, qop_q, qop_d;
  logic                  push, pop, full;
  logic [ACC_WIDTH:0]    sum;
  logic [7:0]            cnt_inc;
  pair_t                 head;

  // Full comes from the registered count only, so a same-cycle pop never frees a slot for a push.
  assign full    = (fcnt_q == CW'(FIFO_DEPTH));
  assign push    = in_valid && !full;
  assign head    = mem_q[rd_ptr_q];
  assign sum     = {1'b0, acc_q} + (ACC_WIDTH+1)'(mul_p);
  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    last_d  = last_q;
    start_d = 1'b0;
    err_d   = err_q;
    timer_d = timer_q;
    m_d     = m_q;
    qop_d   = qop_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fcnt_q != '0 && !mul_busy) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        start_d = 1'b1;
        m_d     = head.m;
        qop_d   = head.q;
        last_d  = head.last;
        pop     = 1'b1;
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        if (mul_done) begin
          acc_d   = sum[ACC_WIDTH-1:0];
          ovf_d   = ovf_q | sum[ACC_WIDTH];
          cnt_d   = cnt_inc;
          state_d = last_q ? S_OUT : S_IDLE;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          // Abandoned product still counts as a pair but adds nothing.
          err_d   = 1'b1;
          cnt_d   = cnt_inc;
          state_d = last_q ? S_OUT : S_IDLE;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    fcnt_d   = fcnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_last, in_q, in_m};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      last_q   <= 1'b0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
      timer_q  <= '0;
      m_q      <= '0;
      qop_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fcnt_q   <= fcnt_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      last_q   <= last_d;
      start_q  <= start_d;
      err_q    <= err_d;
      timer_q  <= timer_d;
      m_q      <= m_d;
      qop_q    <= qop_d;
    end
  end

  assign in_ready    = !full;
  assign out_valid   = (state_q == S_OUT);
  assign out_sum     = acc_q;
  assign out_count   = cnt_q;
  assign out_ovf     = ovf_q;
  assign mul_start   = start_q;
  assign mul_m       = m_q;
  assign mul_q       = qop_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_booth_mac_ctrl.sv
// Bench for booth_mac_ctrl: 24-bit and 16-bit accumulator instances in lockstep, behavioural multiplier,
// table vectors, random vectors against a plain-arithmetic dot-product model, and multi-cycle corner sequences.
module tb_booth_mac_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid, in_last, out_ready, mul_done, mul_busy;
  logic [7:0]  in_m, in_q;
  logic [15:0] mul_p;
  logic        in_ready, out_valid, out_ovf, mul_start, err_timeout;
  logic [7:0]  out_count, mul_m, mul_q;
  logic [23:0] out_sum;
  logic        in_ready16, out_valid16, out_ovf16, mul_start16, err16;
  logic [7:0]  out_count16, mul_m16, mul_q16;
  logic [15:0] out_sum16;

  booth_mac_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_m(in_m), .in_q(in_q),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_count(out_count), .out_ovf(out_ovf), .mul_start(mul_start), .mul_m(mul_m), .mul_q(mul_q),
    .mul_p(mul_p), .mul_done(mul_done), .mul_busy(mul_busy), .err_timeout(err_timeout));

  booth_mac_ctrl #(.ACC_WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16), .in_m(in_m), .in_q(in_q),
    .in_last(in_last), .out_valid(out_valid16), .out_ready(out_ready), .out_sum(out_sum16),
    .out_count(out_count16), .out_ovf(out_ovf16), .mul_start(mul_start16), .mul_m(mul_m16),
    .mul_q(mul_q16), .mul_p(mul_p), .mul_done(mul_done), .mul_busy(mul_busy), .err_timeout(err16));

  typedef struct packed {
    logic [23:0] sum;
    logic [7:0]  cnt;
    logic        ovf;
    logic [15:0] sum16;
    logic        ovf16;
  } res_t;

  typedef struct packed {
    logic [2:0]  n;
    logic [31:0] m;
    logic [31:0] q;
    logic [31:0] sum;
    logic [15:0] sum16;
    logic        ovf16;
  } tv_t;

  res_t   exp_q[$];
  int     vec_cnt = 0, mis_cnt = 0;
  int     cyc = 0, start_cnt = 0, n_pushed = 0;
  int     t_push = 0, t_start = 0, t_done = 0, t_outv = 0, t_err = 0, t_hang = 0;
  bit     hold_out = 1'b0, junk_en = 1'b0, hang_armed = 1'b0;
  longint run_sum = 0;
  int     run_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    vec_cnt++;
    if (act != exp) begin
      mis_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic res_t mk_res(input longint s, input int n);
    res_t r;
    r.sum   = s[23:0];
    r.cnt   = (n > 255) ? 8'd255 : 8'(n);
    r.ovf   = (s >= 64'd16777216);
    r.sum16 = s[15:0];
    r.ovf16 = (s >= 64'd65536);
    return r;
  endfunction

  function automatic tv_t tv(input int n, input logic [31:0] mw, input logic [31:0] qw,
                             input int s, input int s16, input bit o16);
    tv_t t;
    t.n = 3'(n); t.m = mw; t.q = qw; t.sum = 32'(s); t.sum16 = 16'(s16); t.ovf16 = o16;
    return t;
  endfunction

  // Push one pair; the model records the plain-arithmetic dot product per vector.
  task automatic push_pair(input logic [7:0] m, input logic [7:0] q, input bit last,
                           input bit excl, input bit use_model);
    int t;
    @(negedge clk);
    in_valid = 1'b1; in_m = m; in_q = q; in_last = last;
    t = 0;
    while (!in_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("push_accept", in_ready, 1);
    t_push = cyc;
    n_pushed++;
    if (!excl) run_sum += longint'(m) * longint'(q);
    run_n++;
    if (last) begin
      if (use_model) exp_q.push_back(mk_res(run_sum, run_n));
      run_sum = 0;
      run_n = 0;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_mul_start"}, mul_start, 0);
    chk({tag, "_mul_m"}, mul_m, 0);
    chk({tag, "_mul_q"}, mul_q, 0);
    chk({tag, "_out_sum"}, out_sum, 0);
    chk({tag, "_out_count"}, out_count, 0);
    chk({tag, "_out_ovf"}, out_ovf, 0);
    chk({tag, "_err_timeout"}, err_timeout, 0);
    chk({tag, "_in_ready16"}, in_ready16, 1);
  endtask

  // Behavioural multiplier: done 11 negedges after start is seen, optional hang, junk done while idle.
  initial begin : mul_model
    int k;
    logic [7:0] pm, pq;
    bit active, hang;
    k = 0; active = 1'b0; hang = 1'b0; pm = '0; pq = '0;
    mul_done = 1'b0; mul_busy = 1'b0; mul_p = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0; mul_done = 1'b0; mul_busy = 1'b0;
      end else begin
        mul_done = 1'b0;
        mul_p = 16'($urandom);
        if (junk_en && !active && !mul_start && $urandom_range(7) == 0) mul_done = 1'b1;
        if (active) begin
          k++;
          if (k == 1) mul_busy = 1'b1;
          if (k == 11) begin
            mul_busy = 1'b0;
            if (!hang) begin
              mul_done = 1'b1; mul_p = pm * pq; t_done = cyc; active = 1'b0;
            end
          end
          if (hang && k == 32) active = 1'b0;
        end
        if (mul_start) begin
          chk("start_while_busy", active, 0);
          active = 1'b1; k = 0; pm = mul_m; pq = mul_q;
          hang = hang_armed; hang_armed = 1'b0;
          start_cnt++; t_start = cyc;
          if (hang) t_hang = cyc;
        end
      end
    end
  end

  // Result consumer: drives out_ready and checks each accepted result against the expected queue.
  initial begin : monitor
    logic r, prev_ov, prev_err;
    res_t e;
    prev_ov = 1'b0; prev_err = 1'b0; out_ready = 1'b0;
    forever begin
      @(negedge clk);
      r = hold_out ? 1'b0 : ($urandom_range(3) != 0);
      out_ready = r;
      if (out_valid && !prev_ov) t_outv = cyc;
      prev_ov = out_valid;
      if (err_timeout && !prev_err) t_err = cyc;
      prev_err = err_timeout;
      if (out_valid && r) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_sum", out_sum, e.sum);
          chk("out_count", out_count, e.cnt);
          chk("out_ovf", out_ovf, e.ovf);
          chk("out_valid16", out_valid16, 1);
          chk("out_sum16", out_sum16, e.sum16);
          chk("out_ovf16", out_ovf16, e.ovf16);
        end
      end
    end
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation time budget exhausted");
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    tv_t  tbl [7];
    res_t e;
    int   sc0, n0, t, len;
    in_valid = 1'b0; in_m = '0; in_q = '0; in_last = 1'b0;

    tbl[0] = tv(1, 32'h000000C8, 32'h00000064, 20000, 20000, 1'b0);
    tbl[1] = tv(3, 32'h000001FF, 32'h004D01FF, 65026, 65026, 1'b0);
    tbl[2] = tv(2, 32'h0000FFFF, 32'h0000FFFF, 130050, 64514, 1'b1);
    tbl[3] = tv(1, 32'h00000000, 32'h00000000, 0, 0, 1'b0);
    tbl[4] = tv(4, 32'h10101010, 32'h10101010, 1024, 1024, 1'b0);
    tbl[5] = tv(3, 32'h008001FF, 32'h0002FF01, 766, 766, 1'b0);
    tbl[6] = tv(2, 32'h0000FAC8, 32'h0000FAC8, 102500, 36964, 1'b1);

    repeat (3) @(negedge clk);
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table vectors; the first one also checks issue and output latency plus the single start pulse.
    for (int i = 0; i < 7; i++) begin
      sc0 = start_cnt;
      e.sum = tbl[i].sum[23:0]; e.cnt = 8'(tbl[i].n); e.ovf = 1'b0;
      e.sum16 = tbl[i].sum16; e.ovf16 = tbl[i].ovf16;
      exp_q.push_back(e);
      for (int j = 0; j < 32'(tbl[i].n); j++)
        push_pair(tbl[i].m[j*8 +: 8], tbl[i].q[j*8 +: 8], j == 32'(tbl[i].n) - 1, 1'b0, 1'b0);
      if (i == 0) n0 = t_push;
      wait_drain(2000);
      if (i == 0) begin
        chk("single_start_pulse", start_cnt - sc0, 1);
        chk("push_to_start_cycles", t_start - n0, 3);
        chk("done_to_out_valid_cycles", t_outv - t_done, 1);
      end
    end

    // Hold the output while a second vector fills the FIFO; nothing may be lost.
    hold_out = 1'b1;
    n0 = n_pushed;
    sc0 = start_cnt;
    fork
      begin
        push_pair(8'd7, 8'd9, 1'b1, 1'b0, 1'b1);
        for (int j = 0; j < 5; j++) push_pair(8'($urandom), 8'($urandom), j == 4, 1'b0, 1'b1);
      end
      begin
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (in_ready && t < 500);
        chk("full_in_ready", in_ready, 0);
        chk("full_in_ready16", in_ready16, 0);
        chk("full_pairs_accepted", n_pushed - n0, 5);
        t = 0;
        while (!out_valid && t < 500) begin
          @(negedge clk);
          t++;
        end
        chk("held_out_valid", out_valid, 1);
        chk("held_in_ready", in_ready, 0);
        chk("held_no_issue", start_cnt - sc0, 1);
        repeat (5) @(negedge clk);
        chk("held_out_sum_stable", out_sum, 63);
        hold_out = 1'b0;
      end
    join
    wait_drain(3000);

    // Multiplier that never answers: timeout after 32 WAIT cycles, product excluded.
    hang_armed = 1'b1;
    push_pair(8'd10, 8'd10, 1'b0, 1'b1, 1'b1);
    push_pair(8'd3, 8'd4, 1'b1, 1'b0, 1'b1);
    wait_drain(2000);
    chk("err_timeout_set", err_timeout, 1);
    chk("err_timeout16_set", err16, 1);
    chk("timeout_wait_cycles", t_err - t_hang, 32);

    // Random vectors with spurious done pulses outside WAIT and random out_ready.
    junk_en = 1'b1;
    for (int v = 0; v < 25; v++) begin
      len = $urandom_range(1, 5);
      for (int j = 0; j < len; j++)
        push_pair(($urandom_range(3) == 0) ? 8'hFF : 8'($urandom),
                  ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom), j == len - 1, 1'b0, 1'b1);
    end
    wait_drain(5000);

    // Long vector: count saturates and both accumulators overflow.
    for (int j = 0; j < 300; j++)
      push_pair(8'($urandom_range(240, 255)), 8'($urandom_range(240, 255)), j == 299, 1'b0, 1'b1);
    wait_drain(8000);
    junk_en = 1'b0;
    chk("err_timeout_sticky", err_timeout, 1);

    // Reset while WAIT with the FIFO full behind it.
    for (int j = 0; j < 5; j++) push_pair(8'd9, 8'd9, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_rst_in_ready", in_ready, 0);
    chk("pre_rst_mul_m", mul_m, 9);
    #2 rst_n = 1'b0;
    #1 chk_reset("midrst");
    run_sum = 0; run_n = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    sc0 = start_cnt;
    repeat (40) @(negedge clk);
    chk("no_start_after_reset", start_cnt - sc0, 0);
    chk("post_rst_in_ready", in_ready, 1);
    push_pair(8'd5, 8'd6, 1'b1, 1'b0, 1'b1);
    wait_drain(2000);
    chk("post_rst_one_start", start_cnt - sc0, 1);
    chk("post_rst_err_clear", err_timeout, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end
endmodule
